tensor_mma_unit: RTL and testbench
==================================

Name: tensor_mma_unit

Overview:
Parametrised successor to the per-warp tensor operand stage. It collects A, B and C tile fragments per warp from the lane-parallel register read path and round-robin arbitrates among warps whose fragments are complete. It computes D = A*B + C on a TILE_N x TILE_N integer tile in a two-stage pipeline and returns D, with warp id and destination register, over a valid/ready writeback port. It sits between operand read and the writeback arbiter in the tensor execute lane.

Parameters:
TILE_N, 2, tile dimension; NUM_THREADS = TILE_N*TILE_N lanes
DATA_WIDTH, 32, signed element width
NUM_WARPS, 8, independent warp buffers (>=2)
NUM_REGS, 32, register count; RD_W = clog2(NUM_REGS)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand fragment valid
in_ready  out  1  fragment accepted when in_valid&&in_ready
in_wid  in  clog2(NUM_WARPS)  target warp
in_sel  in  2  0=A, 1=B, 2=C, 3=reserved
in_rd  in  RD_W  destination register, captured on C load
in_data  in  NUM_THREADS*DATA_WIDTH  lane r*TILE_N+c carries element (r,c)
out_valid  out  1  result valid
out_ready  in  1  writeback accepts
out_wid  out  clog2(NUM_WARPS)  result warp
out_rd  out  RD_W  result destination
out_data  out  NUM_THREADS*DATA_WIDTH  D, same lane mapping
busy  out  1  any warp not in LOAD or pipe non-empty

Behaviour:
- Clock clk; reset is synchronous and active-high.
- Per-warp state: LOAD, PEND, EXEC; load mask {C,B,A}.
- LOAD: in_ready = (state[in_wid]==LOAD). An accepted sel 0/1/2 writes that operand buffer and sets its mask bit. Reloading an already-set operand overwrites it. sel 3 is accepted and discarded, mask unchanged.
- Mask reaches 3'b111 -> PEND on the next edge. The same-cycle completing load counts.
- PEND: the warp requests the round-robin arbiter. The pointer starts at warp 0 after reset and advances to grant+1 after each grant.
- Pipe advance condition: adv = !out_valid || out_ready. A grant happens only in a cycle with adv=1 and at least one PEND warp. A granted warp -> EXEC.
- Stage 1 registers the NUM_THREADS*TILE_N signed products plus C, wid and rd.
- Stage 2 registers D(r,c) = sum_k A(r,k)*B(k,c) + C(r,c) into the output register, sets out_valid, and drives out_wid/out_rd.
- Latency: out_valid is high 2 cycles after grant with no stall. Throughput is 1 tile/cycle across warps.
- Stall: when adv=0, both stages hold and no grant occurs. out_data/out_wid/out_rd must stay stable while out_valid && !out_ready.
- out_valid&&out_ready: the warp goes EXEC -> LOAD, its mask clears, and it may be reloaded the following cycle. A load to that warp in the handshake cycle is rejected (in_ready=0).
- Arithmetic: products are exact at 2*DATA_WIDTH. Accumulation is at 2*DATA_WIDTH+clog2(TILE_N)+1 bits. By default the result is truncated to the low DATA_WIDTH bits (two's-complement wrap).
- Reset:
  - all warps go to LOAD with mask 0;
  - pipe valids are cleared, so out_valid=0;
  - arbiter pointer = 0;
  - out_wid/out_rd/out_data = 0;
  - busy = 0;
  - operand buffer contents are not reset.
  - Reset mid-operation discards in-flight tiles without producing output.
- in_wid out of range (for non-power-of-2 NUM_WARPS): in_ready=0.

Optional Feature:
TENSOR_MMA_SAT_EN:
- Defined: the full-width accumulation is saturated to the signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] in stage 2. Latency is unchanged.
- Undefined: the result wraps as described in Behaviour.

Test Plan:
- Basic result (TILE_N=2, DATA_WIDTH=16): load warp 3 with A=[[1,2],[3,4]], B=[[5,6],[7,8]], C=[[1,1],[1,1]], rd=9, out_ready=1 -> out_valid 2 cycles after grant; D=[[20,23],[44,51]], out_wid=3, out_rd=9.
- Arbitration: warps 0, 2 and 5 reach PEND in the same cycle -> grants in order 0, 2, 5 on consecutive cycles. The next PEND warp 1 is granted after 5.
- Backpressure: hold out_ready=0 for 5 cycles with two tiles in flight -> out_data/out_wid stable throughout, no new grant, second result appears one cycle after the first handshake.
- Load blocking: load A twice (values 1, then 2) into warp 1 -> the second value is used. Load to warp 1 while PEND/EXEC -> in_ready=0; warp 1 is reloadable the cycle after its result handshake.
- Wrap vs saturation (DATA_WIDTH=16): A(0,0)=B(0,0)=300, others 0, C=0 -> D(0,0)=90000 mod 2^16 = 24464 without the macro; 32767 with TENSOR_MMA_SAT_EN.
- Reset mid-operation: assert reset with one tile in stage 1 -> out_valid stays 0 and busy=0. After reset, in_ready=1 for all warps, and a fresh load/compute gives the correct D.

Source files
------------

// File: rtl/tensor_mma_unit.sv
// Per-warp A/B/C fragment collection, round-robin issue and a two-stage D = A*B + C tile pipeline.
// Define TENSOR_MMA_SAT_EN to saturate results to the signed DATA_WIDTH range instead of wrapping.
module tensor_mma_unit #(
  parameter int  TILE_N     = 2,
  parameter int  DATA_WIDTH = 32,
  parameter int  NUM_WARPS  = 8,
  parameter int  NUM_REGS   = 32,
  localparam int NT         = TILE_N * TILE_N,
  localparam int WID_W      = $clog2(NUM_WARPS),
  localparam int RD_W       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WID_W-1:0]         in_wid,
  input  logic [1:0]               in_sel,
  input  logic [RD_W-1:0]          in_rd,
  input  logic [NT*DATA_WIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WID_W-1:0]         out_wid,
  output logic [RD_W-1:0]          out_rd,
  output logic [NT*DATA_WIDTH-1:0] out_data,
  output logic                     busy,
  output logic [2*NUM_WARPS-1:0]   dbg_state_o
);
  localparam int DW    = DATA_WIDTH;
  localparam int PW    = 2 * DW;
  localparam int ACC_W = PW + $clog2(TILE_N) + 1;
  localparam int VW    = NT * DW;

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
  typedef enum logic [1:0] {W_LOAD = 2'd0, W_PEND = 2'd1, W_EXEC = 2'd2} warp_state_e;

  warp_state_e              state_q [NUM_WARPS];
  warp_state_e              state_d [NUM_WARPS];
  logic [2:0]               mask_q  [NUM_WARPS];
  logic [2:0]               mask_d  [NUM_WARPS];
  logic [VW-1:0]            a_buf_q [NUM_WARPS];
  logic [VW-1:0]            b_buf_q [NUM_WARPS];
  logic [VW-1:0]            c_buf_q [NUM_WARPS];
  logic [RD_W-1:0]          rd_buf_q[NUM_WARPS];
  logic [WID_W-1:0]         rr_ptr_q;
  logic [WID_W-1:0]         rr_idx  [NUM_WARPS];

  logic                     wid_ok, in_fire, adv, out_fire, grant_vld;
  logic [WID_W-1:0]         grant_id;

  logic signed [PW-1:0]     prod_d    [NT*TILE_N];
  logic signed [PW-1:0]     s1_prod_q [NT*TILE_N];
  logic [VW-1:0]            s1_c_q;
  logic                     s1_valid_q;
  logic [WID_W-1:0]         s1_wid_q;
  logic [RD_W-1:0]          s1_rd_q;
  logic [VW-1:0]            res_d;
  logic                     out_valid_q;
  logic [WID_W-1:0]         out_wid_q;
  logic [RD_W-1:0]          out_rd_q;
  logic [VW-1:0]            out_data_q;

  assign wid_ok   = (int'(in_wid) < NUM_WARPS);
  assign in_ready = wid_ok && (state_q[in_wid] == W_LOAD);
  assign in_fire  = in_valid && in_ready;
  assign adv      = !out_valid_q || out_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) rr_idx[i] = WID_W'((int'(rr_ptr_q) + i) % NUM_WARPS);
  end

  // First PEND warp at or after the pointer wins; nothing issues while the pipe is stalled.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    if (adv) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        if (!grant_vld && state_q[rr_idx[i]] == W_PEND) begin
          grant_vld = 1'b1;
          grant_id  = rr_idx[i];
        end
      end
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      state_d[w] = state_q[w];
      mask_d[w]  = mask_q[w];
      case (state_q[w])
        W_LOAD: if (in_fire && in_wid == WID_W'(w) && in_sel != 2'd3) begin
          mask_d[w] = mask_q[w] | (3'b001 << in_sel);
          if (mask_d[w] == 3'b111) state_d[w] = W_PEND;
        end
        W_PEND: if (grant_vld && grant_id == WID_W'(w)) state_d[w] = W_EXEC;
        W_EXEC: if (out_fire && out_wid_q == WID_W'(w)) begin
          state_d[w] = W_LOAD;
          mask_d[w]  = '0;
        end
        default: state_d[w] = W_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_q[w] <= W_LOAD;
        mask_q[w]  <= '0;
      end
      rr_ptr_q <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_q[w] <= state_d[w];
        mask_q[w]  <= mask_d[w];
      end
      if (grant_vld) rr_ptr_q <= (int'(grant_id) == NUM_WARPS - 1) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      case (in_sel)
        2'd0: a_buf_q[in_wid] <= in_data;
        2'd1: b_buf_q[in_wid] <= in_data;
        2'd2: begin
          c_buf_q[in_wid]  <= in_data;
          rd_buf_q[in_wid] <= in_rd;
        end
        default: ;
      endcase
    end
  end

  // Product index (r*TILE_N + c)*TILE_N + k holds A(r,k)*B(k,c).
  always_comb begin
    for (int r = 0; r < TILE_N; r++)
      for (int c = 0; c < TILE_N; c++)
        for (int k = 0; k < TILE_N; k++)
          prod_d[(r*TILE_N+c)*TILE_N+k] =
            PW'($signed(a_buf_q[grant_id][(r*TILE_N+k)*DW +: DW])) *
            PW'($signed(b_buf_q[grant_id][(k*TILE_N+c)*DW +: DW]));
  end

  always_ff @(posedge clk) begin
    if (reset) s1_valid_q <= 1'b0;
    else if (adv) s1_valid_q <= grant_vld;
  end

  always_ff @(posedge clk) begin
    if (adv && grant_vld) begin
      for (int i = 0; i < NT*TILE_N; i++) s1_prod_q[i] <= prod_d[i];
      s1_c_q   <= c_buf_q[grant_id];
      s1_wid_q <= grant_id;
      s1_rd_q  <= rd_buf_q[grant_id];
    end
  end

  always_comb begin
    logic signed [ACC_W-1:0] acc;
    res_d = '0;
    for (int l = 0; l < NT; l++) begin
      acc = ACC_W'($signed(s1_c_q[l*DW +: DW]));
      for (int k = 0; k < TILE_N; k++) acc = acc + ACC_W'(s1_prod_q[l*TILE_N+k]);
`ifdef TENSOR_MMA_SAT_EN
      if (acc[ACC_W-1:DW-1] != {(ACC_W-DW+1){acc[ACC_W-1]}})
        res_d[l*DW +: DW] = acc[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      else
        res_d[l*DW +: DW] = acc[DW-1:0];
`else
      res_d[l*DW +: DW] = acc[DW-1:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_wid_q   <= '0;
      out_rd_q    <= '0;
      out_data_q  <= '0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_wid_q  <= s1_wid_q;
        out_rd_q   <= s1_rd_q;
        out_data_q <= res_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_wid   = out_wid_q;
  assign out_rd    = out_rd_q;
  assign out_data  = out_data_q;

  always_comb begin
    busy        = s1_valid_q || out_valid_q;
    dbg_state_o = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (state_q[w] != W_LOAD) busy = 1'b1;
      dbg_state_o[2*w +: 2] = state_q[w];
    end
  end
endmodule

// File: tb/tb_tensor_mma_unit.sv
// Bench for tensor_mma_unit: directed scenarios plus randomized tiles against a matrix-level reference.
module tb_tensor_mma_unit;
  localparam int TILE_N = 2;
  localparam int DW     = 16;
  localparam int NW     = 8;
  localparam int NR     = 32;
  localparam int NT     = TILE_N * TILE_N;
  localparam int VW     = NT * DW;
  localparam int WID_W  = 3;
  localparam int RD_W   = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready, out_valid, out_ready, busy;
  logic [WID_W-1:0]  in_wid, out_wid;
  logic [1:0]        in_sel;
  logic [RD_W-1:0]   in_rd, out_rd;
  logic [VW-1:0]     in_data, out_data;
  logic [2*NW-1:0]   dbg_state;

  int                chk_cnt = 0;
  int                err_cnt = 0;
  logic [VW-1:0]     m_op [NW][3];
  logic [2:0]        m_mask [NW];
  int                m_rd [NW];
  logic [VW-1:0]     m_exp [NW];
  int                m_exp_rd [NW];
  int                issue_cnt [NW];
  int                done_cnt [NW];
  logic [WID_W-1:0]  exp_q[$];
  bit                rnd_rdy;
  logic [VW-1:0]     hold_data;

  always #5 clk = ~clk;

  tensor_mma_unit #(.TILE_N(TILE_N), .DATA_WIDTH(DW), .NUM_WARPS(NW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_sel(in_sel),
    .in_rd(in_rd), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_rd(out_rd),
    .out_data(out_data), .busy(busy), .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] mat(input int e00, input int e01, input int e10, input int e11);
    mat = {DW'(e11), DW'(e10), DW'(e01), DW'(e00)};
  endfunction

  function automatic longint elem(input logic [VW-1:0] m, input int i);
    logic [DW-1:0] e;
    e = m[i*DW +: DW];
    elem = longint'($signed(e));
  endfunction

  // D = A*B + C with exact integer math, then wrapped or clamped to DW bits.
  function automatic logic [VW-1:0] ref_mma(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                            input logic [VW-1:0] c);
    longint acc, lmax, lmin;
    logic [VW-1:0] d;
    d    = '0;
    lmax = (longint'(1) << (DW - 1)) - 1;
    lmin = -lmax - 1;
    for (int r = 0; r < TILE_N; r++) begin
      for (int cc = 0; cc < TILE_N; cc++) begin
        acc = elem(c, r*TILE_N + cc);
        for (int k = 0; k < TILE_N; k++) acc += elem(a, r*TILE_N + k) * elem(b, k*TILE_N + cc);
`ifdef TENSOR_MMA_SAT_EN
        if (acc > lmax) acc = lmax;
        else if (acc < lmin) acc = lmin;
`endif
        d[(r*TILE_N+cc)*DW +: DW] = acc[DW-1:0];
      end
    end
    ref_mma = d;
  endfunction

  function automatic logic [VW-1:0] rand_mat();
    logic [VW-1:0] m;
    for (int i = 0; i < NT; i++) m[i*DW +: DW] = DW'($urandom);
    rand_mat = m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic load(input int w, input int sel, input logic [VW-1:0] d, input int rd);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_wid   = WID_W'(w);
    in_sel   = 2'(sel);
    in_rd    = RD_W'(rd);
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      step();
      @(negedge clk);
      n++;
    end
    check("load_accept", VW'(in_ready), 1);
    step();
    in_valid = 1'b0;
    if (sel < 3) begin
      m_op[w][sel] = d;
      m_mask[w]    = m_mask[w] | 3'(1 << sel);
    end
    if (sel == 2) m_rd[w] = rd;
    if (m_mask[w] == 3'b111) begin
      m_mask[w]   = '0;
      m_exp[w]    = ref_mma(m_op[w][0], m_op[w][1], m_op[w][2]);
      m_exp_rd[w] = m_rd[w];
      issue_cnt[w]++;
    end
  endtask

  task automatic load_tile(input int w, input logic [VW-1:0] a, input logic [VW-1:0] b,
                           input logic [VW-1:0] c, input int rd);
    load(w, 0, a, $urandom_range(0, NR-1));
    load(w, 1, b, $urandom_range(0, NR-1));
    load(w, 2, c, rd);
  endtask

  task automatic probe(input string tag, input int w, input logic exp);
    in_wid = WID_W'(w);
    @(negedge clk);
    check(tag, VW'(in_ready), VW'(exp));
    step();
  endtask

  task automatic monitor();
    int w;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        w = int'(out_wid);
        check("out_expected", VW'(issue_cnt[w] > done_cnt[w]), 1);
        check("out_rd", VW'(out_rd), VW'(m_exp_rd[w]));
        check("out_data", out_data, m_exp[w]);
        if (exp_q.size() > 0) check("grant_order", VW'(out_wid), VW'(exp_q.pop_front()));
        done_cnt[w]++;
      end
    end
  endtask

  task automatic drain();
    int  n;
    bit  idle;
    n    = 0;
    idle = 1'b0;
    while (!idle && n < 400) begin
      idle = 1'b1;
      for (int w = 0; w < NW; w++) if (issue_cnt[w] != done_cnt[w]) idle = 1'b0;
      if (exp_q.size() != 0) idle = 1'b0;
      if (!idle) begin
        step();
        n++;
      end
    end
    check("drain_done", VW'(idle), 1);
    step();
    check("idle_busy", VW'(busy), 0);
  endtask

  initial begin
    int w, sel_order[3], tmp, j;
    reset = 1'b1; in_valid = 1'b0; in_wid = '0; in_sel = '0; in_rd = '0; in_data = '0;
    out_ready = 1'b1; rnd_rdy = 1'b0;
    for (int i = 0; i < NW; i++) begin
      m_mask[i] = '0; issue_cnt[i] = 0; done_cnt[i] = 0; m_rd[i] = 0; m_exp_rd[i] = 0;
    end
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_out_valid", VW'(out_valid), 0);
    check("rst_busy", VW'(busy), 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_wid", VW'(out_wid), 0);
    check("rst_out_rd", VW'(out_rd), 0);
    for (int i = 0; i < NW; i++) probe("rst_in_ready", i, 1'b1);

    // Basic 2x2 result and two-cycle latency
    load_tile(3, mat(1, 2, 3, 4), mat(5, 6, 7, 8), mat(1, 1, 1, 1), 9);
    check("basic_busy", VW'(busy), 1);
    check("basic_lat0", VW'(out_valid), 0);
    probe("basic_pend_blocked", 3, 1'b0);
    check("basic_lat1", VW'(out_valid), 0);
    step();
    check("basic_valid", VW'(out_valid), 1);
    check("basic_data", out_data, mat(20, 23, 44, 51));
    check("basic_wid", VW'(out_wid), 3);
    check("basic_rd", VW'(out_rd), 9);
    step();
    check("basic_done", VW'(out_valid), 0);

    // Two tiles in flight, then backpressure and round-robin order
    out_ready = 1'b0;
    load(6, 0, rand_mat(), 0); load(6, 1, rand_mat(), 0);
    load(7, 0, rand_mat(), 0); load(7, 1, rand_mat(), 0);
    load(6, 2, rand_mat(), 11);
    load(7, 2, rand_mat(), 12);
    step();
    exp_q.push_back(3'd6); exp_q.push_back(3'd7);
    check("stall_valid", VW'(out_valid), 1);
    check("stall_wid", VW'(out_wid), 6);
    hold_data = out_data;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_hold_valid", VW'(out_valid), 1);
      check("stall_hold_wid", VW'(out_wid), 6);
      check("stall_hold_data", out_data, hold_data);
    end
    probe("exec_blocked", 6, 1'b0);
    load_tile(0, rand_mat(), rand_mat(), rand_mat(), 1);
    load_tile(2, rand_mat(), rand_mat(), rand_mat(), 2);
    load_tile(5, rand_mat(), rand_mat(), rand_mat(), 5);
    load(1, 0, rand_mat(), 0); load(1, 1, rand_mat(), 0);
    exp_q.push_back(3'd0); exp_q.push_back(3'd2); exp_q.push_back(3'd5); exp_q.push_back(3'd1);
    check("stall_no_grant_wid", VW'(out_wid), 6);
    check("stall_no_grant_data", out_data, hold_data);
    out_ready = 1'b1;
    step();
    check("second_valid", VW'(out_valid), 1);
    check("second_wid", VW'(out_wid), 7);
    load(1, 2, rand_mat(), 21);
    drain();

    // Operand reload and in_ready blocking on warp 1
    load(1, 0, mat(1, 1, 1, 1), 0);
    load(1, 0, mat(2, 2, 2, 2), 0);
    load(1, 1, mat(1, 0, 0, 1), 0);
    load(1, 2, mat(0, 0, 0, 0), 17);
    probe("reload_pend_blocked", 1, 1'b0);
    probe("reload_exec_blocked", 1, 1'b0);
    check("reload_data", out_data, mat(2, 2, 2, 2));
    check("reload_rd", VW'(out_rd), 17);
    probe("handshake_blocked", 1, 1'b0);
    probe("reload_ready_after", 1, 1'b1);

    // Wrap vs saturation
    load_tile(4, mat(300, 0, 0, 0), mat(300, 0, 0, 0), mat(0, 0, 0, 0), 2);
    step();
    step();
    check("sat_valid", VW'(out_valid), 1);
`ifdef TENSOR_MMA_SAT_EN
    check("sat_data", out_data, mat(32767, 0, 0, 0));
`else
    check("wrap_data", out_data, mat(24464, 0, 0, 0));
`endif
    step();

    // Reset with a tile in stage 1
    load(0, 0, rand_mat(), 0);
    load_tile(2, rand_mat(), rand_mat(), rand_mat(), 4);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    issue_cnt[2]--;
    for (int i = 0; i < NW; i++) m_mask[i] = '0;
    check("rstmid_valid", VW'(out_valid), 0);
    check("rstmid_busy", VW'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstmid_quiet", VW'(out_valid), 0);
    end
    for (int i = 0; i < NW; i++) probe("rstmid_in_ready", i, 1'b1);
    load_tile(2, mat(1, 2, 3, 4), mat(5, 6, 7, 8), mat(1, 1, 1, 1), 9);
    step();
    step();
    check("rstmid_fresh_data", out_data, mat(20, 23, 44, 51));
    check("rstmid_fresh_wid", VW'(out_wid), 2);
    drain();

    // Randomized tiles with random backpressure, operand order, reloads and reserved selects
    rnd_rdy = 1'b1;
    for (int t = 0; t < 40; t++) begin
      w = -1;
      for (int n = 0; n < 300 && w < 0; n++) begin
        tmp = $urandom_range(0, NW-1);
        for (int i = 0; i < NW; i++)
          if (w < 0 && issue_cnt[(tmp+i)%NW] == done_cnt[(tmp+i)%NW]) w = (tmp + i) % NW;
        if (w < 0) step();
      end
      check("rand_free_warp", VW'(w >= 0), 1);
      if (w < 0) w = 0;
      sel_order[0] = 0; sel_order[1] = 1; sel_order[2] = 2;
      for (int i = 2; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = sel_order[i]; sel_order[i] = sel_order[j]; sel_order[j] = tmp;
      end
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 3) == 0) load(w, sel_order[i], rand_mat(), $urandom_range(0, NR-1));
        if ($urandom_range(0, 4) == 0) load(w, 3, rand_mat(), $urandom_range(0, NR-1));
        load(w, sel_order[i], rand_mat(), $urandom_range(0, NR-1));
      end
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end
endmodule
